hash_arbiter: RTL and testbench
===============================

HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SHAKE hash core.
REQ-002 Parameter IO_WIDTH, default 32, word width of the RAM, length and digest buses.
REQ-003 Parameter ADDR_WIDTH, default 4, width of the RAM word address.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, watchdog limit; used only when the watchdog is compiled in.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester job request.
REQ-008 req_in_len / req_out_len  in  NUM_REQ*IO_WIDTH each  per-requester message and digest lengths in bits; slot k occupies bits [k*IO_WIDTH +: IO_WIDTH].
REQ-009 req_grant  out  NUM_REQ  one-hot owner of the core; all zero when idle.
REQ-010 req_rd_addr  out  ADDR_WIDTH  RAM address, broadcast to all requesters.
REQ-011 req_rd_en  out  NUM_REQ  RAM read enable, driven only on the granted slot.
REQ-012 req_rd_data  in  NUM_REQ*IO_WIDTH  per-requester RAM read data.
REQ-013 req_dout  out  IO_WIDTH  digest word, broadcast to all requesters.
REQ-014 req_dout_valid  out  NUM_REQ  digest valid, driven only on the granted slot.
REQ-015 req_dout_ready  in  NUM_REQ  per-requester digest ready.
REQ-016 req_done / req_err  out  NUM_REQ each  one-cycle completion and abort pulses.
REQ-017 Core-side ports:
- h_start, h_in_len, h_out_len: out.
- h_addr, h_rd_en, h_dout, h_dout_valid, h_done: in.
- h_dout_ready: out.
- h_force_done: out.
- h_force_done_ack: in.

Function
REQ-018 States: IDLE, START, RUN, FLUSH, FIN.
REQ-019 IDLE: when any req_valid is high, select one requester round-robin, starting at rr_ptr and searching upward with wrap.
- Latch the selected index, its in_len and its out_len.
- Set req_grant.
- Go to START.
REQ-020 START: assert h_start for exactly one cycle, with h_in_len and h_out_len taken from the latched values; then go to RUN.
REQ-021 RUN datapath routing, all combinational and registered on neither path:
- req_rd_addr = h_addr[ADDR_WIDTH-1:0].
- req_rd_en[g] = h_rd_en.
- The core read data is req_rd_data slot g.
- req_dout = h_dout, req_dout_valid[g] = h_dout_valid, h_dout_ready = req_dout_ready[g].
REQ-022 Ungranted slots SHALL see rd_en = 0 and dout_valid = 0 at all times.
REQ-023 Word count: words_needed = out_len >> log2(IO_WIDTH), plus 1 when out_len mod IO_WIDTH != 0.
REQ-024 beat_cnt SHALL increment on each h_dout_valid && h_dout_ready cycle while in RUN.
REQ-025 RUN -> FLUSH when beat_cnt == words_needed and a sticky h_done flag (set in RUN or START) is high.
- After the last beat is accepted, h_dout_ready SHALL be forced low.
- When out_len = 0, the transition occurs on h_done alone.
REQ-026 FLUSH: hold h_force_done high until h_force_done_ack is sampled high, then go to FIN; h_dout_ready is low throughout.
REQ-027 FIN: pulse req_done[g] (or req_err[g] if the job aborted), set rr_ptr = (g+1) mod NUM_REQ, clear req_grant, go to IDLE.
REQ-028 Idle cycles: the arbiter SHALL be idle for at least one cycle between jobs.
- START to first-grant latency from IDLE is 1 cycle.
REQ-029 Mid-job request changes: req_valid deassertion or length changes SHALL be ignored; the latched values govern the job.
REQ-030 Requests arriving in the same cycle are resolved purely by the round-robin order; no requester waits more than NUM_REQ-1 jobs.

Reset
REQ-031 On rst, go to IDLE with rr_ptr = 0, counters and flags cleared, and every output 0, including req_grant, h_start, h_force_done and all pulses.
REQ-032 rst asserted mid-job SHALL abandon the job immediately without pulsing req_done or req_err; the core is reset by the same rst.

Configuration
REQ-033 Macro HASH_ARB_WATCHDOG_EN.
- When defined: a counter in RUN resets on any h_rd_en or accepted digest beat and otherwise increments.
- On reaching TIMEOUT_CYCLES, the state SHALL go to FLUSH with an abort flag set, so FIN pulses req_err instead of req_done.
- When undefined: no counter exists, RUN waits indefinitely, and req_err is tied to 0.

Structure
REQ-034 Shared package hash_arb_pkg SHALL hold the state encoding, the default TIMEOUT_CYCLES and the round-robin next-index function.
REQ-035 Sub-module rr_picker (NUM_REQ, combinational one-hot select from req_valid and rr_ptr) SHALL be instantiated once.

Verification
REQ-036 Single job: req_valid = 0001, in_len = 256, out_len = 256.
- Response: one h_start, 8 digest beats on slot 0, force_done/ack handshake, then req_done = 0001 once.
REQ-037 Contention: req_valid = 1111 held continuously.
- Response: grants in order 0,1,2,3,0, each job completing before the next grant.
REQ-038 Non-multiple length: out_len = 80.
- Response: exactly 3 beats accepted, and h_dout_ready is low after the third beat.
REQ-039 Back-pressure: req_dout_ready toggled 1/0 each cycle.
- Response: beat_cnt advances only on handshake cycles, and no beat is lost or duplicated.
REQ-040 Watchdog, with HASH_ARB_WATCHDOG_EN defined and TIMEOUT_CYCLES = 16: hold req_dout_ready = 0.
- Response: FLUSH is entered after 16 idle cycles, followed by a req_err pulse and no req_done.
REQ-041 Reset mid-job: assert rst during RUN.
- Response: all outputs are 0 on the next cycle, and the next grant goes to slot 0.

Source files
------------

// File: rtl/hash_arb_pkg.sv
// Shared definitions for hash_arbiter: FSM encoding, watchdog default and
// round-robin pointer advance.
package hash_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    FLUSH,
    FIN
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/hash_arbiter_if.sv
// Core-side bus between hash_arbiter (master) and the shared SHAKE core (slave).
interface hash_arbiter_if #(
  parameter int unsigned IO_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  h_start;
  logic [IO_WIDTH-1:0]   h_in_len;
  logic [IO_WIDTH-1:0]   h_out_len;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic                  h_rd_en;
  logic [IO_WIDTH-1:0]   h_rd_data;
  logic [IO_WIDTH-1:0]   h_dout;
  logic                  h_dout_valid;
  logic                  h_dout_ready;
  logic                  h_done;
  logic                  h_force_done;
  logic                  h_force_done_ack;

  modport master (
    output h_start, h_in_len, h_out_len, h_rd_data, h_dout_ready, h_force_done,
    input  h_addr, h_rd_en, h_dout, h_dout_valid, h_done, h_force_done_ack
  );

  modport slave (
    input  h_start, h_in_len, h_out_len, h_rd_data, h_dout_ready, h_force_done,
    output h_addr, h_rd_en, h_dout, h_dout_valid, h_done, h_force_done_ack
  );
endinterface

// File: rtl/hash_arbiter_rr_picker.sv
// Combinational round-robin one-hot select: first valid requester at or above
// the pointer, wrapping around.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot
);
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_idx = IDX_W'((32'(i_ptr) + off) % NUM_REQ);
      if (!w_found && i_valid[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one SHAKE core among NUM_REQ requesters.
// Optional RUN watchdog compiled in with macro HASH_ARB_WATCHDOG_EN.
module hash_arbiter
  import hash_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IO_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_in_len,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_out_len,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic [ADDR_WIDTH-1:0]        req_rd_addr,
  output logic [NUM_REQ-1:0]           req_rd_en,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_rd_data,
  output logic [IO_WIDTH-1:0]          req_dout,
  output logic [NUM_REQ-1:0]           req_dout_valid,
  input  logic [NUM_REQ-1:0]           req_dout_ready,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_err,
  hash_arbiter_if.master               core
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LOG2W = $clog2(IO_WIDTH);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_rr_ptr, r_sel, w_sel_idx;
  logic [NUM_REQ-1:0]  w_pick, r_grant, r_done;
  logic [IO_WIDTH-1:0] r_in_len, r_out_len, r_beat, w_words;
  logic                r_start, r_force, r_hdone;
  logic                w_run, w_dout_ready, w_beat, w_complete, w_wd_fire, w_abort;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_valid  (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (w_pick[i]) w_sel_idx = IDX_W'(i);
  end

  assign w_words      = (r_out_len >> LOG2W) + IO_WIDTH'(|r_out_len[LOG2W-1:0]);
  assign w_run        = (r_state == RUN);
  // Ready drops as soon as the last beat has been accepted.
  assign w_dout_ready = w_run && (r_beat != w_words) && req_dout_ready[r_sel];
  assign w_beat       = w_dout_ready && core.h_dout_valid;
  assign w_complete   = (r_beat == w_words) && (r_hdone || core.h_done);

  always_comb begin
    req_rd_addr    = '0;
    req_rd_en      = '0;
    req_dout       = '0;
    req_dout_valid = '0;
    core.h_rd_data = '0;
    if (w_run) begin
      req_rd_addr           = core.h_addr;
      req_rd_en[r_sel]      = core.h_rd_en;
      core.h_rd_data        = req_rd_data[r_sel*IO_WIDTH +: IO_WIDTH];
      req_dout              = core.h_dout;
      req_dout_valid[r_sel] = core.h_dout_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_grant   <= '0;
      r_in_len  <= '0;
      r_out_len <= '0;
      r_beat    <= '0;
      r_start   <= 1'b0;
      r_force   <= 1'b0;
      r_hdone   <= 1'b0;
      r_done    <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      unique case (r_state)
        IDLE: if (|req_valid) begin
          r_sel     <= w_sel_idx;
          r_grant   <= w_pick;
          r_in_len  <= req_in_len[w_sel_idx*IO_WIDTH +: IO_WIDTH];
          r_out_len <= req_out_len[w_sel_idx*IO_WIDTH +: IO_WIDTH];
          r_beat    <= '0;
          r_hdone   <= 1'b0;
          r_start   <= 1'b1;
          r_state   <= START;
        end
        START: begin
          r_hdone <= core.h_done;
          r_state <= RUN;
        end
        RUN: begin
          if (w_beat)      r_beat  <= r_beat + IO_WIDTH'(1);
          if (core.h_done) r_hdone <= 1'b1;
          if (w_complete || w_wd_fire) begin
            r_force <= 1'b1;
            r_state <= FLUSH;
          end
        end
        FLUSH: if (core.h_force_done_ack) begin
          r_force <= 1'b0;
          r_done  <= w_abort ? '0 : r_grant;
          r_state <= FIN;
        end
        FIN: begin
          r_rr_ptr <= IDX_W'(rr_next(32'(r_sel), NUM_REQ));
          r_grant  <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HASH_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    r_wdog;
  logic               r_abort;
  logic [NUM_REQ-1:0] r_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive RUN cycle without progress.
  assign w_wd_fire = w_run && !(core.h_rd_en || w_beat) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_abort   = r_abort;
  assign req_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst || !w_run || core.h_rd_en || w_beat) r_wdog <= '0;
    else                                         r_wdog <= r_wdog + WD_W'(1);
    if (rst || r_state == IDLE)                  r_abort <= 1'b0;
    else if (w_wd_fire && !w_complete)           r_abort <= 1'b1;
    if (rst) r_err <= '0;
    else     r_err <= (r_state == FLUSH && core.h_force_done_ack && r_abort) ? r_grant : '0;
  end
`else
  assign w_wd_fire = 1'b0;
  assign w_abort   = 1'b0;
  assign req_err   = '0;
`endif

  assign req_grant         = r_grant;
  assign req_done          = r_done;
  assign core.h_start      = r_start;
  assign core.h_in_len     = r_in_len;
  assign core.h_out_len    = r_out_len;
  assign core.h_force_done = r_force;
  assign core.h_dout_ready = w_dout_ready;
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter with a behavioural SHAKE core model.
module tb_hash_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]   req_valid, req_grant, req_rd_en, req_dout_valid, req_dout_ready, req_done, req_err;
  logic [NR*W-1:0] req_in_len, req_out_len, req_rd_data;
  logic [AW-1:0]   req_rd_addr;
  logic [W-1:0]    req_dout;

  hash_arbiter_if #(.IO_WIDTH(W), .ADDR_WIDTH(AW)) core_if ();

  hash_arbiter #(.NUM_REQ(NR), .IO_WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_in_len(req_in_len),
    .req_out_len(req_out_len), .req_grant(req_grant), .req_rd_addr(req_rd_addr),
    .req_rd_en(req_rd_en), .req_rd_data(req_rd_data), .req_dout(req_dout),
    .req_dout_valid(req_dout_valid), .req_dout_ready(req_dout_ready),
    .req_done(req_done), .req_err(req_err), .core(core_if)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n_start = 0, n_done = 0, n_err = 0, n_log = 0;
  int c_sent, c_words, c_rd, c_idle, c_fcnt, idle_at_force, bp_mode = 0, exp_idx;
  logic c_busy = 1'b0, c_done_sent, rdy_checked, hs;
  logic [NR-1:0] s_grant, last_done, last_err;
  logic [W-1:0]  s_in_len, s_out_len;
  logic [NR-1:0] grant_log [0:15];

  // Core model: drives at negedge+1, samples the coming handshake at negedge+2.
  initial begin
    core_if.h_addr = '0; core_if.h_rd_en = 1'b0; core_if.h_dout = '0;
    core_if.h_dout_valid = 1'b0; core_if.h_done = 1'b0; core_if.h_force_done_ack = 1'b0;
    req_dout_ready = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        core_if.h_rd_en = 1'b0; core_if.h_dout_valid = 1'b0; core_if.h_done = 1'b0;
        core_if.h_force_done_ack = 1'b0; req_dout_ready = '0; c_busy = 1'b0;
        continue;
      end
      if (req_done != '0) begin n_done++; last_done = req_done; end
      if (req_err  != '0) begin n_err++;  last_err  = req_err;  end
      if (core_if.h_start) begin
        check("serial", 64'(n_done + n_err), 64'(n_start));
        n_start++;
        s_grant = req_grant; s_in_len = core_if.h_in_len; s_out_len = core_if.h_out_len;
        if (n_log < 16) begin grant_log[n_log] = req_grant; n_log++; end
        c_words = int'((s_out_len + 31) / 32);
        c_sent = 0; c_rd = 4; c_busy = 1'b1; c_done_sent = 1'b0; rdy_checked = 1'b0;
        c_idle = 0; c_fcnt = 0; idle_at_force = -1;
      end
      core_if.h_force_done_ack = 1'b0;
      if (core_if.h_force_done && c_busy) begin
        c_fcnt++;
        if (c_fcnt == 1) idle_at_force = c_idle;
        if (c_fcnt == 2) begin core_if.h_force_done_ack = 1'b1; c_busy = 1'b0; end
      end
      core_if.h_done = 1'b0;
      if (c_busy) begin
        if (c_rd > 0) c_rd--;
        core_if.h_rd_en      = (c_rd == 2 || c_rd == 1);
        core_if.h_addr       = AW'(c_rd);
        core_if.h_dout_valid = (c_rd == 0 && c_sent < c_words);
        core_if.h_dout       = 32'hD000_0000 + W'(c_sent);
        if (c_rd == 0 && c_sent == c_words && !c_done_sent) begin
          core_if.h_done = 1'b1; c_done_sent = 1'b1;
        end
      end else begin
        core_if.h_rd_en = 1'b0; core_if.h_dout_valid = 1'b0;
      end
      case (bp_mode)
        0:       req_dout_ready = '1;
        1:       req_dout_ready = ~req_dout_ready;
        default: req_dout_ready = '0;
      endcase
      #1;
      hs = core_if.h_dout_valid && core_if.h_dout_ready;
      if (c_busy) begin
        check("no_leak", 64'((req_rd_en | req_dout_valid) & ~s_grant), 64'(0));
        if (c_rd == 0 && c_sent == c_words && !rdy_checked) begin
          check("rdy_low_after_last", 64'(core_if.h_dout_ready), 64'(0));
          rdy_checked = 1'b1;
        end
        if (core_if.h_rd_en) begin
          exp_idx = 0;
          for (int k = 0; k < NR; k++) if (s_grant[k]) exp_idx = k;
          check("rd_en", 64'(req_rd_en), 64'(s_grant));
          check("rd_addr", 64'(req_rd_addr), 64'(c_rd));
          check("rd_data", 64'(core_if.h_rd_data), 64'(32'hAAAA_0000 + W'(exp_idx)));
        end
        if (hs) begin
          check("dout", 64'(req_dout), 64'(32'hD000_0000 + W'(c_sent)));
          check("dout_vld", 64'(req_dout_valid), 64'(s_grant));
          c_sent++;
        end
        if (core_if.h_rd_en || hs) c_idle = 0;
        else                       c_idle++;
      end
    end
  end

  task automatic set_lens(input int unsigned in_len, input int unsigned out_len);
    for (int k = 0; k < NR; k++) begin
      req_in_len[k*W +: W]  = W'(in_len);
      req_out_len[k*W +: W] = W'(out_len);
    end
  endtask

  task automatic wait_start(input int target, input string tag);
    for (int i = 0; i < 300 && n_start < target; i++) @(negedge clk);
    if (n_start < target) check({tag, "_start_timeout"}, 64'(n_start), 64'(target));
  endtask

  task automatic wait_end(input int target, input string tag);
    for (int i = 0; i < 400 && (n_done + n_err) < target; i++) @(negedge clk);
    check({tag, "_end"}, 64'(n_done + n_err), 64'(target));
  endtask

  task automatic run_job(input logic [NR-1:0] valid, input int unsigned in_len,
                         input int unsigned out_len, input int bp,
                         input logic [NR-1:0] exp_grant, input int exp_beats, input string tag);
    int base_s, base_d, base_e;
    base_s = n_start; base_d = n_done; base_e = n_err;
    @(negedge clk);
    set_lens(in_len, out_len); req_valid = valid; bp_mode = bp;
    wait_start(base_s + 1, tag);
    req_valid = '0;
    set_lens(32'h20, 32'h20);
    wait_end(base_d + base_e + 1, tag);
    repeat (2) @(negedge clk);
    check({tag, "_grant"},  64'(s_grant),   64'(exp_grant));
    check({tag, "_inlen"},  64'(s_in_len),  64'(in_len));
    check({tag, "_outlen"}, 64'(s_out_len), 64'(out_len));
    check({tag, "_beats"},  64'(c_sent),    64'(exp_beats));
    check({tag, "_done"},   64'(last_done), 64'(exp_grant));
    check({tag, "_ndone"},  64'(n_done),    64'(base_d + 1));
    check({tag, "_nerr"},   64'(n_err),     64'(base_e));
  endtask

  initial begin
    int base_log, base_d;
    rst = 1'b1; req_valid = '0; set_lens(0, 0);
    for (int k = 0; k < NR; k++) req_rd_data[k*W +: W] = 32'hAAAA_0000 + W'(k);
    repeat (3) @(negedge clk);
    #3;
    check("rst_grant", 64'(req_grant), 64'(0));
    check("rst_start", 64'(core_if.h_start), 64'(0));
    check("rst_force", 64'(core_if.h_force_done), 64'(0));
    check("rst_done",  64'(req_done), 64'(0));
    check("rst_err",   64'(req_err), 64'(0));
    check("rst_rd_en", 64'(req_rd_en), 64'(0));
    check("rst_dvld",  64'(req_dout_valid), 64'(0));
    check("rst_rdy",   64'(core_if.h_dout_ready), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_job(4'b0001, 256, 256, 0, 4'b0001, 8, "single");
    run_job(4'b0001, 256,  80, 0, 4'b0001, 3, "len80");
    run_job(4'b0100, 512, 256, 1, 4'b0100, 8, "bp");
    run_job(4'b1000,  64,   0, 0, 4'b1000, 0, "len0");

    // Contention: pointer is back at 0, so grants must cycle 0,1,2,3,0.
    base_log = n_log; base_d = n_done + n_err;
    @(negedge clk);
    set_lens(128, 64); bp_mode = 0; req_valid = 4'b1111;
    wait_start(n_start + 5, "contend");
    req_valid = '0;
    wait_end(base_d + 5, "contend");
    for (int k = 0; k < 5; k++)
      check("contend_order", 64'(grant_log[base_log + k]), 64'(4'b0001 << (k % 4)));

    // Reset in the middle of a stalled job.
    base_d = n_done;
    @(negedge clk);
    set_lens(256, 256); bp_mode = 2; req_valid = 4'b0010;
    wait_start(n_start + 1, "midrst");
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("midrst_grant_before", 64'(req_grant), 64'(4'b0010));
    rst = 1'b1;
    @(negedge clk); #3;
    check("midrst_grant", 64'(req_grant), 64'(0));
    check("midrst_start", 64'(core_if.h_start), 64'(0));
    check("midrst_force", 64'(core_if.h_force_done), 64'(0));
    check("midrst_rd_en", 64'(req_rd_en), 64'(0));
    check("midrst_dvld",  64'(req_dout_valid), 64'(0));
    check("midrst_rdy",   64'(core_if.h_dout_ready), 64'(0));
    check("midrst_dout",  64'(req_dout), 64'(0));
    check("midrst_addr",  64'(req_rd_addr), 64'(0));
    check("midrst_done",  64'(req_done | req_err), 64'(0));
    @(negedge clk);
    rst = 1'b0; bp_mode = 0;
    n_start = n_done + n_err;
    check("midrst_no_pulse", 64'(n_done), 64'(base_d));
    run_job(4'b1111, 128, 64, 0, 4'b0001, 2, "post_rst");

`ifdef HASH_ARB_WATCHDOG_EN
    base_d = n_done;
    @(negedge clk);
    set_lens(256, 256); bp_mode = 2; req_valid = 4'b0010;
    wait_start(n_start + 1, "wdog");
    req_valid = '0;
    wait_end(n_done + n_err + 1, "wdog");
    repeat (2) @(negedge clk);
    check("wdog_err",     64'(last_err), 64'(4'b0010));
    check("wdog_no_done", 64'(n_done), 64'(base_d));
    check("wdog_idle",    64'(idle_at_force), 64'(TO));
    check("wdog_beats",   64'(c_sent), 64'(0));
`else
    check("no_err_pulse", 64'(n_err), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end
endmodule
